// File: rtl/gshare_pht_predictor_pkg.sv
// ---------------------------------------------------------------------------
// gshare_pht_predictor_pkg
//
// Shared definitions for the gshare direction predictor:
//   - pht_state_e    : 2-bit saturating counter states (SNT/WNT/WT/ST)
//   - PHT_RESET      : value every PHT entry takes on reset (weakly not-taken)
//   - *_DEFAULT      : default parameter values for the predictor top
//   - pht_taken()    : direction implied by a counter state (its MSB)
// ---------------------------------------------------------------------------
package gshare_pht_predictor_pkg;

    typedef enum logic [1:0] {
        PHT_SNT = 2'b00,    // strongly not-taken
        PHT_WNT = 2'b01,    // weakly not-taken
        PHT_WT  = 2'b10,    // weakly taken
        PHT_ST  = 2'b11     // strongly taken
    } pht_state_e;

    localparam pht_state_e PHT_RESET = PHT_WNT;

    localparam int GHR_W_DEFAULT  = 8;
    localparam int PC_LSB_DEFAULT = 2;
    localparam int CNT_W_DEFAULT  = 32;

    // The two taken states share MSB = 1, so the prediction is just that bit.
    function automatic logic pht_taken(input pht_state_e state);
        return state[1];
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// ---------------------------------------------------------------------------
// sat_counter2
//
// Pure next-state function of a 2-bit saturating branch counter.
// Taken moves one step toward ST, not-taken one step toward SNT; both ends
// hold their value instead of wrapping.
//
// Ports
//   i_cnt    in   pht_state_e   current counter state
//   i_taken  in   1             resolved outcome (1 = taken)
//   o_next   out  pht_state_e   counter state after applying the outcome
// ---------------------------------------------------------------------------
module sat_counter2
    import gshare_pht_predictor_pkg::*;
(
    input  pht_state_e i_cnt,
    input  logic       i_taken,
    output pht_state_e o_next
);

    always_comb begin
        // NOTE: assigning a default before any branch means every path drives
        // o_next, so this block can never infer a latch.
        o_next = i_cnt;
        if (i_taken) begin
            if (i_cnt != PHT_ST) begin
                o_next = pht_state_e'(i_cnt + 2'd1);
            end
        end else begin
            if (i_cnt != PHT_SNT) begin
                o_next = pht_state_e'(i_cnt - 2'd1);
            end
        end
    end

endmodule

// File: rtl/gshare_pht_predictor.sv
// ---------------------------------------------------------------------------
// gshare_pht_predictor
//
// Gshare direction predictor. A table of 2**GHR_W two-bit saturating counters
// (PHT) is indexed by the fetch PC XORed with the global history (GHSR).
//   - Fetch side: combinational lookup, prediction in the same cycle.
//   - Execute side: on the update strobe, the counter at the index captured
//     at fetch is trained with the resolved outcome, the outcome is shifted
//     into the GHSR, and the branch / mispredict statistics advance.
// History is non-speculative: it only moves on resolved branches.
//
// Parameters
//   GHR_W   history width; PHT depth is 2**GHR_W
//   PC_LSB  lowest PC bit used for indexing (2 for word-aligned RV32I)
//   CNT_W   width of the statistics counters
//
// Ports
//   i_clk              in   1      clock, all state on rising edge
//   i_rst_n            in   1      asynchronous active-low reset
//   i_pc_F             in   32     fetch-stage PC
//   o_predict_PHT      out  1      prediction for i_pc_F (1 = taken)
//   o_pht_idx_F        out  GHR_W  PHT index used for i_pc_F
//   i_update_PHT_GHSR  in   1      update strobe for a resolved branch in E
//   i_pht_idx_E        in   GHR_W  index captured at fetch for the branch in E
//   i_actual_branch    in   1      resolved outcome (1 = taken)
//   i_mispre           in   1      branch in E was mispredicted
//   o_ghsr             out  GHR_W  current global history (newest in LSB)
//   o_branch_cnt       out  CNT_W  resolved conditional branches (saturating)
//   o_mispre_cnt       out  CNT_W  mispredicted branches (saturating)
// ---------------------------------------------------------------------------
module gshare_pht_predictor
    import gshare_pht_predictor_pkg::*;
#(
    parameter int GHR_W  = GHR_W_DEFAULT,
    parameter int PC_LSB = PC_LSB_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_pc_F,
    output logic             o_predict_PHT,
    output logic [GHR_W-1:0] o_pht_idx_F,
    input  logic             i_update_PHT_GHSR,
    input  logic [GHR_W-1:0] i_pht_idx_E,
    input  logic             i_actual_branch,
    input  logic             i_mispre,
    output logic [GHR_W-1:0] o_ghsr,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispre_cnt
);

    localparam int              PHT_DEPTH = 1 << GHR_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    pht_state_e       r_pht [PHT_DEPTH];
    logic [GHR_W-1:0] r_ghsr;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispre_cnt;

    // -----------------------------------------------------------------------
    // Fetch-side lookup (0-cycle latency)
    // -----------------------------------------------------------------------
    logic [GHR_W-1:0] w_pc_bits;
    logic [GHR_W-1:0] w_pht_idx_F;
    pht_state_e       w_pht_rd;
    logic             w_unused_pc;

    assign w_pc_bits   = i_pc_F[PC_LSB+GHR_W-1:PC_LSB];
    assign w_pht_idx_F = w_pc_bits ^ r_ghsr;
    // The lookup reads the registered table directly: an update landing on
    // the same entry this cycle is seen only from the next cycle.
    assign w_pht_rd    = r_pht[w_pht_idx_F];

    // PC bits above the index and the byte offset do not take part in
    // indexing; folded here so they are visibly consumed.
    assign w_unused_pc = ^{i_pc_F[31:PC_LSB+GHR_W], i_pc_F[PC_LSB-1:0]};

    assign o_pht_idx_F   = w_pht_idx_F;
    assign o_predict_PHT = pht_taken(w_pht_rd);

    // -----------------------------------------------------------------------
    // Execute-side training
    // -----------------------------------------------------------------------
    pht_state_e w_pht_cur_E;
    pht_state_e w_pht_next_E;

    assign w_pht_cur_E = r_pht[i_pht_idx_E];

    sat_counter2 u_sat_counter2 (
        .i_cnt   (w_pht_cur_E),
        .i_taken (i_actual_branch),
        .o_next  (w_pht_next_E)
    );

    // NOTE: the PHT is deliberately reset entry by entry. Its reset value
    // (weakly not-taken) is architectural, so it must be a flop array; an
    // SRAM could not be cleared in one asynchronous event like this.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                r_pht[i] <= PHT_RESET;
            end
        end else if (i_update_PHT_GHSR) begin
            r_pht[i_pht_idx_E] <= w_pht_next_E;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or process order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ghsr <= '0;
        end else if (i_update_PHT_GHSR) begin
            // Newest outcome enters at the LSB; the oldest falls off the MSB.
            r_ghsr <= {r_ghsr[GHR_W-2:0], i_actual_branch};
        end
    end

    // -----------------------------------------------------------------------
    // Statistics: saturating at all-ones so long runs never wrap to a small
    // misleading value.
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_branch_cnt <= '0;
            r_mispre_cnt <= '0;
        end else if (i_update_PHT_GHSR) begin
            if (r_branch_cnt != CNT_MAX) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (i_mispre && (r_mispre_cnt != CNT_MAX)) begin
                r_mispre_cnt <= r_mispre_cnt + CNT_W'(1);
            end
        end
    end

    assign o_ghsr       = r_ghsr;
    assign o_branch_cnt = r_branch_cnt;
    assign o_mispre_cnt = r_mispre_cnt;

endmodule

// File: tb/tb_gshare_pht_predictor.sv
// ---------------------------------------------------------------------------
// tb_gshare_pht_predictor
//
// Directed bench for gshare_pht_predictor. A second instance with CNT_W = 4
// shares all inputs so the statistics saturation point is reachable quickly.
// ---------------------------------------------------------------------------
module tb_gshare_pht_predictor;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        upd;
    logic [7:0]  upd_idx;
    logic        taken;
    logic        mispre;

    logic        pred;
    logic [7:0]  pht_idx_f;
    logic [7:0]  ghsr;
    logic [31:0] br_cnt;
    logic [31:0] mis_cnt;

    logic        s_pred;
    logic [7:0]  s_pht_idx_f;
    logic [7:0]  s_ghsr;
    logic [3:0]  s_br_cnt;
    logic [3:0]  s_mis_cnt;

    int n_checks = 0;
    int n_errors = 0;

    gshare_pht_predictor #(.GHR_W(8), .PC_LSB(2), .CNT_W(32)) u_dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_pc_F            (pc),
        .o_predict_PHT     (pred),
        .o_pht_idx_F       (pht_idx_f),
        .i_update_PHT_GHSR (upd),
        .i_pht_idx_E       (upd_idx),
        .i_actual_branch   (taken),
        .i_mispre          (mispre),
        .o_ghsr            (ghsr),
        .o_branch_cnt      (br_cnt),
        .o_mispre_cnt      (mis_cnt)
    );

    gshare_pht_predictor #(.GHR_W(8), .PC_LSB(2), .CNT_W(4)) u_dut_small (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_pc_F            (pc),
        .o_predict_PHT     (s_pred),
        .o_pht_idx_F       (s_pht_idx_f),
        .i_update_PHT_GHSR (upd),
        .i_pht_idx_E       (upd_idx),
        .i_actual_branch   (taken),
        .i_mispre          (mispre),
        .o_ghsr            (s_ghsr),
        .o_branch_cnt      (s_br_cnt),
        .o_mispre_cnt      (s_mis_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       upd;
        logic [7:0] upd_idx;
        logic       taken;
        logic       mispre;
        logic [7:0] rd_idx;
        logic [7:0] exp_ghsr;
        logic       exp_pred;
        int         exp_br;
        int         exp_mis;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        upd    = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
    endtask

    // One resolved-branch update across a rising edge; returns 1 ns after it.
    task automatic do_upd(input logic [7:0] idx, input logic t, input logic m);
        @(negedge clk);
        upd     = 1'b1;
        upd_idx = idx;
        taken   = t;
        mispre  = m;
        @(posedge clk);
        #1;
        upd     = 1'b0;
        mispre  = 1'b0;
    endtask

    task automatic read_pc(input logic [31:0] p);
        pc = p;
        #1;
    endtask

    logic hist [9];

    initial begin
        rst_n   = 1'b0;
        pc      = 32'h0;
        upd     = 1'b0;
        upd_idx = 8'h0;
        taken   = 1'b0;
        mispre  = 1'b0;

        // Saturation walk at idx 0x10 plus strobe-low and untouched-entry rows.
        //           upd   uidx   tk    mis   ridx   ghsr   pred  br  mis
        vecs[0]  = '{1'b1, 8'h10, 1'b1, 1'b0, 8'h10, 8'h01, 1'b1, 1,  0};
        vecs[1]  = '{1'b1, 8'h10, 1'b1, 1'b0, 8'h10, 8'h03, 1'b1, 2,  0};
        vecs[2]  = '{1'b1, 8'h10, 1'b1, 1'b0, 8'h10, 8'h07, 1'b1, 3,  0};
        vecs[3]  = '{1'b1, 8'h10, 1'b1, 1'b0, 8'h10, 8'h0F, 1'b1, 4,  0};
        vecs[4]  = '{1'b1, 8'h10, 1'b1, 1'b0, 8'h10, 8'h1F, 1'b1, 5,  0};
        vecs[5]  = '{1'b1, 8'h10, 1'b0, 1'b1, 8'h10, 8'h3E, 1'b1, 6,  1};
        vecs[6]  = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h10, 8'h7C, 1'b0, 7,  1};
        vecs[7]  = '{1'b1, 8'h10, 1'b0, 1'b0, 8'h10, 8'hF8, 1'b0, 8,  1};
        vecs[8]  = '{1'b1, 8'h10, 1'b0, 1'b1, 8'h10, 8'hF0, 1'b0, 9,  2};
        vecs[9]  = '{1'b0, 8'h10, 1'b1, 1'b1, 8'h10, 8'hF0, 1'b0, 9,  2};
        vecs[10] = '{1'b1, 8'h10, 1'b1, 1'b0, 8'h10, 8'hE1, 1'b0, 10, 2};
        vecs[11] = '{1'b1, 8'h10, 1'b1, 1'b0, 8'h10, 8'hC3, 1'b1, 11, 2};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h55, 8'hC3, 1'b0, 11, 2};

        hist = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        read_pc(32'h100);
        check("rst_ghsr",    32'(ghsr),      32'h0);
        check("rst_br",      br_cnt,         32'h0);
        check("rst_mis",     mis_cnt,        32'h0);
        check("rst_idx_100", 32'(pht_idx_f), 32'h40);
        check("rst_pred_100", 32'(pred),     32'h0);
        read_pc(32'h2FC);
        check("rst_idx_2fc", 32'(pht_idx_f), 32'hBF);
        check("rst_pred_2fc", 32'(pred),     32'h0);

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            upd     = vecs[i].upd;
            upd_idx = vecs[i].upd_idx;
            taken   = vecs[i].taken;
            mispre  = vecs[i].mispre;
            pc      = {22'b0, vecs[i].rd_idx ^ vecs[i].exp_ghsr, 2'b00};
            @(posedge clk);
            #1;
            upd    = 1'b0;
            mispre = 1'b0;
            check($sformatf("vec%0d_ghsr", i), 32'(ghsr),      32'(vecs[i].exp_ghsr));
            check($sformatf("vec%0d_idx", i),  32'(pht_idx_f), 32'(vecs[i].rd_idx));
            check($sformatf("vec%0d_pred", i), 32'(pred),      32'(vecs[i].exp_pred));
            check($sformatf("vec%0d_br", i),   br_cnt,         32'(vecs[i].exp_br));
            check($sformatf("vec%0d_mis", i),  mis_cnt,        32'(vecs[i].exp_mis));
        end

        // ---------------- train ----------------
        do_reset();
        do_upd(8'h41, 1'b1, 1'b0);
        read_pc(32'h100);
        check("train_ghsr", 32'(ghsr),      32'h01);
        check("train_idx",  32'(pht_idx_f), 32'h41);
        check("train_pred", 32'(pred),      32'h1);

        // ---------------- history ----------------
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_upd(8'h00, hist[i], 1'b0);
        end
        check("hist_8", 32'(ghsr), 32'hB2);
        do_upd(8'h00, hist[8], 1'b0);
        check("hist_9", 32'(ghsr), 32'h65);

        // ---------------- same-cycle collision ----------------
        do_reset();
        @(negedge clk);
        pc      = 32'h100;
        upd     = 1'b1;
        upd_idx = 8'h40;
        taken   = 1'b1;
        #1;
        check("coll_idx_old",  32'(pht_idx_f), 32'h40);
        check("coll_pred_old", 32'(pred),      32'h0);
        @(posedge clk);
        #1;
        upd = 1'b0;
        check("coll_ghsr", 32'(ghsr), 32'h01);
        read_pc(32'h104);
        check("coll_idx_new",  32'(pht_idx_f), 32'h40);
        check("coll_pred_new", 32'(pred),      32'h1);

        // ---------------- statistics ----------------
        do_reset();
        do_upd(8'h05, 1'b1, 1'b0);
        do_upd(8'h06, 1'b0, 1'b1);
        do_upd(8'h07, 1'b1, 1'b0);
        check("stat_br3",  br_cnt,  32'd3);
        check("stat_mis1", mis_cnt, 32'd1);
        @(negedge clk);
        mispre = 1'b1;
        @(posedge clk);
        #1;
        mispre = 1'b0;
        check("stat_nostrobe_br",  br_cnt,  32'd3);
        check("stat_nostrobe_mis", mis_cnt, 32'd1);
        check("small_br3",  32'(s_br_cnt),  32'd3);
        check("small_mis1", 32'(s_mis_cnt), 32'd1);
        for (int i = 0; i < 20; i++) begin
            do_upd(8'h08, 1'b1, 1'b1);
        end
        check("stat_br23",   br_cnt,          32'd23);
        check("stat_mis21",  mis_cnt,         32'd21);
        check("small_br_sat",  32'(s_br_cnt),  32'd15);
        check("small_mis_sat", 32'(s_mis_cnt), 32'd15);

        // ---------------- reset mid-traffic ----------------
        // Train the entries pc 0x100 / 0x2FC will hit once history is cleared.
        do_upd(8'h40, 1'b1, 1'b0);
        do_upd(8'h40, 1'b1, 1'b0);
        do_upd(8'hBF, 1'b1, 1'b0);
        do_upd(8'hBF, 1'b1, 1'b0);
        @(negedge clk);
        upd     = 1'b1;
        upd_idx = 8'h40;
        taken   = 1'b1;
        mispre  = 1'b1;
        pc      = 32'h100;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ghsr", 32'(ghsr), 32'h0);
        check("midrst_br",   br_cnt,    32'h0);
        check("midrst_mis",  mis_cnt,   32'h0);
        check("midrst_small_br", 32'(s_br_cnt), 32'h0);
        check("midrst_pred_100", 32'(pred), 32'h0);
        read_pc(32'h2FC);
        check("midrst_idx_2fc",  32'(pht_idx_f), 32'hBF);
        check("midrst_pred_2fc", 32'(pred),       32'h0);
        // Strobe stays high across an edge while reset is held: nothing moves.
        @(posedge clk);
        @(negedge clk);
        upd    = 1'b0;
        mispre = 1'b0;
        rst_n  = 1'b1;
        read_pc(32'h100);
        check("postrst_ghsr", 32'(ghsr), 32'h0);
        check("postrst_br",   br_cnt,    32'h0);
        check("postrst_pred_100", 32'(pred), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
